// File: rtl/iv_sched_ctrl.sv
// IV issue scheduler: seeds an external LFSR, warms it up, then hands out one
// IV at a time to two round-robin requesters until the seed budget is spent.
module iv_sched_ctrl #(
    parameter int unsigned WARMUP_STEPS = 16,
    parameter int unsigned STEPS_PER_IV = 1,
    parameter int unsigned RESEED_LIMIT = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         seed_valid,
    input  logic [127:0] seed,
    input  logic         req0,
    input  logic         req1,
    output logic         ack0,
    output logic         ack1,
    output logic [127:0] iv_out,
    output logic         lfsr_enable,
    output logic         lfsr_load,
    output logic [127:0] lfsr_seed,
    input  logic [127:0] lfsr_iv,
    output logic         ready,
    output logic         reseed_req,
    output logic         seed_err,
    output logic [31:0]  iv_count
);

    typedef enum logic [2:0] {
        S_UNSEEDED = 3'd0,
        S_LOAD     = 3'd1,
        S_WARMUP   = 3'd2,
        S_READY    = 3'd3,
        S_STEP     = 3'd4,
        S_GRANT    = 3'd5
    } state_e;

    localparam logic [31:0] WARM_LAST = 32'(WARMUP_STEPS - 1);
    localparam logic [31:0] STEP_LAST = 32'(STEPS_PER_IV - 1);
    localparam logic [31:0] LIMIT     = 32'(RESEED_LIMIT);

    state_e       state_q, state_d;
    logic [31:0]  cnt_q, cnt_d;
    logic [31:0]  iv_count_q, iv_count_d;
    logic         ptr_q, ptr_d;
    logic         winner_q, winner_d;
    logic [127:0] iv_q, iv_d;
    logic [127:0] seed_q, seed_d;
    logic         ack0_q, ack0_d;
    logic         ack1_q, ack1_d;
    logic         load_q, load_d;
    logic         en_q, en_d;
    logic         ready_q, ready_d;
    logic         reseed_q, reseed_d;
    logic         err_q, err_d;

    // Next-state, counters and registered-output values.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        iv_count_d = iv_count_q;
        ptr_d      = ptr_q;
        winner_d   = winner_q;
        iv_d       = iv_q;
        seed_d     = seed_q;
        err_d      = err_q;

        case (state_q)
            S_UNSEEDED: state_d = S_UNSEEDED;
            S_LOAD: begin
                state_d = S_WARMUP;
                cnt_d   = 32'd0;
            end
            S_WARMUP: begin
                if (cnt_q == WARM_LAST) begin
                    state_d = S_READY;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_READY: begin
                if ((iv_count_q < LIMIT) && (req0 || req1)) begin
                    winner_d = (req0 && req1) ? ptr_q : req1;
                    cnt_d    = 32'd0;
                    state_d  = S_STEP;
                end else begin
                    state_d = S_READY;
                end
            end
            S_STEP: begin
                if (cnt_q == STEP_LAST) begin
                    state_d = S_GRANT;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_GRANT: begin
                state_d = S_READY;
                iv_d    = lfsr_iv;
                ptr_d   = ~winner_q;
                if (iv_count_q < LIMIT) begin
                    iv_count_d = iv_count_q + 32'd1;
                end else begin
                    iv_count_d = iv_count_q;
                end
            end
            default: state_d = S_UNSEEDED;
        endcase

        // An accepted seed overrides whatever the FSM was doing, including a STEP.
        if (seed_valid && (seed != 128'd0)) begin
            seed_d     = seed;
            iv_count_d = 32'd0;
            err_d      = 1'b0;
            state_d    = S_LOAD;
        end else if (seed_valid) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end

        ack0_d   = (state_d == S_GRANT) && !winner_d;
        ack1_d   = (state_d == S_GRANT) && winner_d;
        load_d   = (state_d == S_LOAD);
        en_d     = (state_d == S_WARMUP) || (state_d == S_STEP);
        ready_d  = (state_d == S_READY);
        reseed_d = (iv_count_d >= LIMIT);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_UNSEEDED;
            cnt_q      <= 32'd0;
            iv_count_q <= 32'd0;
            ptr_q      <= 1'b0;
            winner_q   <= 1'b0;
            iv_q       <= 128'd0;
            seed_q     <= 128'd0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            load_q     <= 1'b0;
            en_q       <= 1'b0;
            ready_q    <= 1'b0;
            reseed_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            iv_count_q <= iv_count_d;
            ptr_q      <= ptr_d;
            winner_q   <= winner_d;
            iv_q       <= iv_d;
            seed_q     <= seed_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            load_q     <= load_d;
            en_q       <= en_d;
            ready_q    <= ready_d;
            reseed_q   <= reseed_d;
            err_q      <= err_d;
        end
    end

    // The LFSR has finished its last step by GRANT, so the IV is passed straight through.
    assign iv_out      = (state_q == S_GRANT) ? lfsr_iv : iv_q;
    assign ack0        = ack0_q;
    assign ack1        = ack1_q;
    assign lfsr_enable = en_q;
    assign lfsr_load   = load_q;
    assign lfsr_seed   = seed_q;
    assign ready       = ready_q;
    assign reseed_req  = reseed_q;
    assign seed_err    = err_q;
    assign iv_count    = iv_count_q;

endmodule

// File: tb/tb_iv_sched_ctrl.sv
// Bench for iv_sched_ctrl: a stub LFSR plus a timeline-level reference model
// feeding a scoreboard that a separate monitor drains on every ack.
module tb_iv_sched_ctrl;

    localparam int W = 16;
    localparam int S = 1;
    localparam int L = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         seed_valid = 1'b0;
    logic [127:0] seed = 128'd0;
    logic         req0 = 1'b0;
    logic         req1 = 1'b0;
    logic         ack0, ack1, lfsr_enable, lfsr_load, ready, reseed_req, seed_err;
    logic [127:0] iv_out, lfsr_seed, lfsr_iv;
    logic [31:0]  iv_count;
    logic [127:0] lfsr_q = 128'd0;

    always #5 clk = ~clk;

    iv_sched_ctrl #(.WARMUP_STEPS(W), .STEPS_PER_IV(S), .RESEED_LIMIT(L)) dut (
        .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed(seed),
        .req0(req0), .req1(req1), .ack0(ack0), .ack1(ack1), .iv_out(iv_out),
        .lfsr_enable(lfsr_enable), .lfsr_load(lfsr_load), .lfsr_seed(lfsr_seed),
        .lfsr_iv(lfsr_iv), .ready(ready), .reseed_req(reseed_req),
        .seed_err(seed_err), .iv_count(iv_count)
    );

    function automatic logic [127:0] lfsr_next(input logic [127:0] x);
        return {x[126:0], x[127] ^ x[125] ^ x[100] ^ x[98]};
    endfunction

    function automatic logic [127:0] adv(input logic [127:0] s, input int n);
        logic [127:0] x;
        x = s;
        for (int i = 0; i < n; i++) x = lfsr_next(x);
        return x;
    endfunction

    // Stand-in LFSR driven by the controller
    always @(posedge clk) begin
        if (lfsr_load) lfsr_q <= lfsr_seed;
        else if (lfsr_enable) lfsr_q <= lfsr_next(lfsr_q);
    end
    assign lfsr_iv = lfsr_q;

    typedef struct {
        int           a;
        bit           w;
        logic [127:0] iv;
        int           idx;
    } exp_t;
    exp_t sb[$];

    int           cyc = 0;
    int           n_checks = 0;
    int           n_fail = 0;
    bit           m_seeded = 1'b0;
    bit           m_err = 1'b0;
    bit           m_ptr = 1'b0;
    bit           m_ptr_save = 1'b0;
    bit           m_pend = 1'b0;
    int           m_pend_a = -100;
    int           m_ready_from = 1 << 30;
    int           m_load_cyc = -100;
    int           m_cnt = 0;
    logic [127:0] m_seed = 128'd0;
    logic [127:0] m_last = 128'd0;
    logic [127:0] m_prev = 128'd0;

    // Reference model: predicts the effect of clock edge e given the inputs sampled there.
    task automatic model_step(input int e, input bit r, input bit sv, input logic [127:0] sd,
                              input bit q0, input bit q1);
        bit ready_now;
        bit w;
        ready_now = m_seeded && ((e - 1) >= m_ready_from);
        if (r) begin
            if (m_pend && m_pend_a >= e) void'(sb.pop_back());
            m_pend = 1'b0; m_seeded = 1'b0; m_err = 1'b0; m_ptr = 1'b0; m_cnt = 0;
            m_last = 128'd0; m_prev = 128'd0; m_ready_from = 1 << 30; m_load_cyc = -100;
        end else if (sv && sd != 128'd0) begin
            if (m_pend && m_pend_a >= e) begin
                void'(sb.pop_back());
                m_last = m_prev;
                m_ptr  = m_ptr_save;
            end
            m_pend = 1'b0; m_seeded = 1'b1; m_seed = sd; m_cnt = 0; m_err = 1'b0;
            m_load_cyc = e; m_ready_from = e + W + 1;
        end else begin
            if (sv) m_err = 1'b1;
            if (ready_now && m_cnt < L && (q0 || q1)) begin
                w = (q0 && q1) ? m_ptr : q1;
                m_ptr_save = m_ptr;
                m_ptr = !w;
                m_cnt++;
                m_prev = m_last;
                m_last = adv(m_seed, W + m_cnt * S);
                m_pend = 1'b1;
                m_pend_a = e + S;
                m_ready_from = m_pend_a + 1;
                sb.push_back('{m_pend_a, w, m_last, m_cnt - 1});
            end
        end
    endtask

    task automatic step(input bit r, input bit sv, input logic [127:0] sd, input bit q0, input bit q1);
        @(negedge clk);
        rst = r; seed_valid = sv; seed = sd; req0 = q0; req1 = q1;
        model_step(cyc + 1, r, sv, sd, q0, q1);
        @(posedge clk);
        cyc = cyc + 1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: per-cycle status checks and scoreboard drain on acks
    initial begin
        int  vis;
        bit  exp_en;
        forever begin
            @(posedge clk);
            #1;
            vis = m_cnt - ((m_pend && cyc <= m_pend_a) ? 1 : 0);
            exp_en = m_seeded && (((cyc > m_load_cyc) && (cyc <= m_load_cyc + W)) ||
                                  (m_pend && cyc >= m_pend_a - S && cyc < m_pend_a));
            chk("ready", ready, m_seeded && cyc >= m_ready_from);
            chk("iv_count", iv_count, vis);
            chk("reseed_req", reseed_req, vis >= L);
            chk("seed_err", seed_err, m_err);
            chk("lfsr_load", lfsr_load, m_seeded && cyc == m_load_cyc);
            chk("lfsr_enable", lfsr_enable, exp_en);
            chk("load_en_excl", lfsr_load & lfsr_enable, 1'b0);
            chk("iv_out", iv_out, (m_pend && cyc < m_pend_a) ? m_prev : m_last);
            while (sb.size() > 0 && sb[0].a < cyc) begin
                chk("ack_missed", 1'b0, 1'b1);
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].a == cyc) begin
                chk("ack0", ack0, !sb[0].w);
                chk("ack1", ack1, sb[0].w);
                chk("ack_iv", iv_out, sb[0].iv);
                chk("ack_count", iv_count, sb[0].idx);
                void'(sb.pop_front());
            end else begin
                chk("no_ack", {ack0, ack1}, 2'b00);
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 128'd0, 1'b0, 1'b0);
        // Zero seed and requests while unseeded
        step(1'b0, 1'b1, 128'd0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 128'd0, 1'b1, 1'b0);
        // Seed 5, warm-up, both requesters, then req0 alone until budget is spent
        step(1'b0, 1'b1, 128'h5, 1'b0, 1'b0);
        for (int i = 0; i < W + 2; i++) step(1'b0, 1'b0, 128'd0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 128'd0, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 128'd0, 1'b1, 1'b0);
        // Zero seed then seed 7; abort a STEP with seed 9
        step(1'b0, 1'b1, 128'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 128'h7, 1'b0, 1'b0);
        for (int i = 0; i < W + 1; i++) step(1'b0, 1'b0, 128'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 128'd0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 128'h9, 1'b0, 1'b0);
        for (int i = 0; i < W + 10; i++) step(1'b0, 1'b0, 128'd0, 1'b1, 1'b0);
        // Reset in the middle of warm-up; requests then ignored
        step(1'b0, 1'b1, 128'h11, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 128'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 128'd0, 1'b1, 1'b0);
        for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 128'd0, 1'b1, 1'b0);
        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            logic [127:0] sd;
            bit           r;
            bit           sv;
            r  = ($urandom_range(0, 299) == 0);
            sv = ($urandom_range(0, 49) == 0);
            sd = ($urandom_range(0, 3) == 0) ? 128'd0 : {$urandom, $urandom, $urandom, $urandom};
            step(r, sv, sd, $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 128'd0, 1'b0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
